// File: rtl/trena_uc.sv
// Control unit for the tape-measure datapath: clear, measure with timeout, send 3 digits plus '#'.
// Optional continuous mode is enabled by defining TRENA_UC_CONTINUO_EN.
module trena_uc #(
   parameter int TIMEOUT_CICLOS   = 2_500_000,
   parameter int INTERVALO_CICLOS = 25_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mensurar,
   input  logic       continuo,
   input  logic       fim_medida,
   input  logic       fim_digito,
   input  logic       fim_envio,
   output logic       zera,
   output logic       medir,
   output logic       conta,
   output logic       partida,
   output logic       pronto,
   output logic       erro,
   output logic [3:0] db_estado
);

   localparam int MAXC = (TIMEOUT_CICLOS > INTERVALO_CICLOS) ? TIMEOUT_CICLOS : INTERVALO_CICLOS;
   localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CICLOS - 1);

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARACAO     = 4'd1,
      MEDIDA         = 4'd2,
      AGUARDA_MEDIDA = 4'd3,
      TRANSMISSAO    = 4'd4,
      ESPERA_DIGITO  = 4'd5,
      PROXIMO        = 4'd6,
      FINAL          = 4'd7,
      INTERVALO      = 4'd8,
      ERRO           = 4'd14
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [CW-1:0] cnt_q, cnt_d;

`ifdef TRENA_UC_CONTINUO_EN
   localparam logic [CW-1:0] INT_LAST = CW'(INTERVALO_CICLOS - 1);
`else
   logic unused_continuo;
   assign unused_continuo = continuo;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= INICIAL;
         cnt_q    <= '0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      case (estado_q)
         INICIAL:        if (mensurar) estado_d = PREPARACAO;
         PREPARACAO:     estado_d = MEDIDA;
         MEDIDA: begin
            cnt_d    = '0;
            estado_d = AGUARDA_MEDIDA;
         end
         AGUARDA_MEDIDA: begin
            // A completed measurement beats a timeout landing on the same cycle
            if (fim_medida)            estado_d = TRANSMISSAO;
            else if (cnt_q == TMO_LAST) estado_d = ERRO;
            else                        cnt_d    = cnt_q + 1'b1;
         end
         TRANSMISSAO:    estado_d = ESPERA_DIGITO;
         ESPERA_DIGITO:  if (fim_digito) estado_d = PROXIMO;
         PROXIMO:        estado_d = fim_envio ? FINAL : TRANSMISSAO;
`ifdef TRENA_UC_CONTINUO_EN
         FINAL: begin
            if (continuo) begin
               cnt_d    = '0;
               estado_d = INTERVALO;
            end else begin
               estado_d = INICIAL;
            end
         end
         INTERVALO: begin
            if (!continuo)              estado_d = INICIAL;
            else if (cnt_q == INT_LAST) estado_d = PREPARACAO;
            else                        cnt_d    = cnt_q + 1'b1;
         end
`else
         FINAL:          estado_d = INICIAL;
`endif
         ERRO:           if (mensurar) estado_d = PREPARACAO;
         default:        estado_d = INICIAL;
      endcase
   end

   always_comb begin
      zera    = 1'b0;
      medir   = 1'b0;
      conta   = 1'b0;
      partida = 1'b0;
      pronto  = 1'b0;
      erro    = 1'b0;
      case (estado_q)
         PREPARACAO:  zera    = 1'b1;
         MEDIDA:      medir   = 1'b1;
         TRANSMISSAO: partida = 1'b1;
         PROXIMO:     conta   = 1'b1;
         FINAL:       pronto  = 1'b1;
         ERRO:        erro    = 1'b1;
         default: ;
      endcase
   end

   assign db_estado = estado_q;

endmodule

// File: tb/tb_trena_uc.sv
// Scoreboard bench for trena_uc: expected output pulses are queued as stimulus is driven
// and matched in order by a monitor on the falling edge.
module tb_trena_uc;

   logic clock = 1'b0;
   logic reset, mensurar, continuo, fim_medida, fim_digito, fim_envio;
   logic zera, medir, conta, partida, pronto, erro;
   logic [3:0] db_estado;

   int checks = 0;
   int errors = 0;
   int n_partida = 0;
   int n_conta = 0;
   logic [4:0] exp_q[$];

   localparam logic [4:0] P_ZERA = 5'b00001, P_MEDIR = 5'b00010, P_PART = 5'b00100,
                          P_CONTA = 5'b01000, P_PRONTO = 5'b10000;

   trena_uc #(.TIMEOUT_CICLOS(100), .INTERVALO_CICLOS(50)) dut (
      .clock(clock), .reset(reset), .mensurar(mensurar), .continuo(continuo),
      .fim_medida(fim_medida), .fim_digito(fim_digito), .fim_envio(fim_envio),
      .zera(zera), .medir(medir), .conta(conta), .partida(partida),
      .pronto(pronto), .erro(erro), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // Pulse monitor: every pulse seen must be the next one the scoreboard expects
   always @(negedge clock) begin
      logic [4:0] obs, e;
      if (!reset) begin
         obs = {pronto, conta, partida, medir, zera};
         if (obs != 5'b0) begin
            if (partida) n_partida++;
            if (conta) n_conta++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pulse_unexpected got %b expected none", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  errors++;
                  $display("FAIL pulse_order got %b expected %b", obs, e);
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk_state(input string name, input logic [3:0] exp);
      checks++;
      if (db_estado !== exp) begin
         errors++;
         $display("FAIL %s db_estado got %0d expected %0d", name, db_estado, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; mensurar = 1'b0; continuo = 1'b0;
      fim_medida = 1'b0; fim_digito = 1'b0; fim_envio = 1'b0;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if ({zera, medir, conta, partida, pronto, erro} !== 6'b0 || db_estado !== 4'd0) begin
         errors++;
         $display("FAIL reset outs got %b state %0d expected 0", {zera, medir, conta, partida, pronto, erro}, db_estado);
      end
   endtask

   // From INICIAL/ERRO: pulse mensurar and follow to AGUARDA_MEDIDA
   task automatic start_meas(input string name);
      exp_q.push_back(P_ZERA);
      exp_q.push_back(P_MEDIR);
      mensurar = 1'b1;
      tick();
      mensurar = 1'b0;
      chk_state({name, "_prep"}, 4'd1);
      checks++;
      if (zera !== 1'b1 || erro !== 1'b0) begin
         errors++;
         $display("FAIL %s_zera zera=%b erro=%b expected 1/0", name, zera, erro);
      end
      tick();
      chk_state({name, "_medida"}, 4'd2);
      tick();
      chk_state({name, "_aguarda"}, 4'd3);
   endtask

   // From AGUARDA_MEDIDA: finish measurement and send the four characters
   task automatic send_all(input string name, input logic [3:0] after_final);
      int p0, c0;
      p0 = n_partida; c0 = n_conta;
      repeat (8) tick();
      exp_q.push_back(P_PART);
      fim_medida = 1'b1;
      tick();
      fim_medida = 1'b0;
      chk_state({name, "_tx0"}, 4'd4);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_state({name, "_espera"}, 4'd5);
         repeat (19) tick();
         exp_q.push_back(P_CONTA);
         fim_digito = 1'b1;
         tick();
         fim_digito = 1'b0;
         chk_state({name, "_proximo"}, 4'd6);
         exp_q.push_back(k == 3 ? P_PRONTO : P_PART);
         fim_envio = (k == 3);
         tick();
         fim_envio = 1'b0;
         chk_state({name, k == 3 ? "_final" : "_tx"}, k == 3 ? 4'd7 : 4'd4);
      end
      tick();
      chk_state({name, "_after_final"}, after_final);
      checks++;
      if (n_partida - p0 != 4 || n_conta - c0 != 4) begin
         errors++;
         $display("FAIL %s_counts partida=%0d conta=%0d expected 4/4", name, n_partida - p0, n_conta - c0);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending got %0d expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_sequence();
      start_meas("seq");
      send_all("seq", 4'd0);
   endtask

   task automatic test_timeout();
      start_meas("tmo");
      repeat (99) tick();
      chk_state("tmo_99", 4'd3);
      tick();
      chk_state("tmo_100", 4'd14);
      checks++;
      if (erro !== 1'b1) begin
         errors++;
         $display("FAIL tmo_erro got %b expected 1", erro);
      end
      repeat (3) tick();
      chk_state("tmo_hold", 4'd14);
      start_meas("tmo_retry");
   endtask

   task automatic test_ignored();
      mensurar = 1'b1; fim_digito = 1'b1;
      repeat (5) tick();
      mensurar = 1'b0; fim_digito = 1'b0;
      chk_state("ign_aguarda", 4'd3);
      exp_q.push_back(P_PART);
      fim_medida = 1'b1;
      tick();
      fim_medida = 1'b0;
      chk_state("ign_tx", 4'd4);
      tick();
      chk_state("ign_espera", 4'd5);
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_state("rst_mid", 4'd0);
      checks++;
      if ({zera, medir, conta, partida, pronto, erro} !== 6'b0) begin
         errors++;
         $display("FAIL rst_mid outs got %b expected 0", {zera, medir, conta, partida, pronto, erro});
      end
      tick();
      chk_state("rst_idle", 4'd0);
      start_meas("rst_restart");
      send_all("rst_restart", 4'd0);
   endtask

`ifdef TRENA_UC_CONTINUO_EN
   task automatic test_continuo();
      continuo = 1'b1;
      start_meas("cont");
      send_all("cont", 4'd8);
      exp_q.push_back(P_ZERA);
      exp_q.push_back(P_MEDIR);
      repeat (50) tick();
      chk_state("cont_prep51", 4'd1);
      tick();
      chk_state("cont_medir52", 4'd2);
      checks++;
      if (medir !== 1'b1) begin
         errors++;
         $display("FAIL cont_medir got %b expected 1", medir);
      end
      tick();
      send_all("cont2", 4'd8);
      repeat (5) tick();
      continuo = 1'b0;
      tick();
      chk_state("cont_drop", 4'd0);
      repeat (60) tick();
      chk_state("cont_idle", 4'd0);
   endtask
`endif

   initial begin
      test_reset();
      test_sequence();
      test_timeout();
      test_ignored();
      test_reset_mid();
`ifdef TRENA_UC_CONTINUO_EN
      test_continuo();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_pending got %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trena_uc.md
Name: trena_uc

Overview:
Control unit for the digital tape-measure datapath. On a start pulse it:
- clears the datapath,
- fires one HC-SR04 measurement and waits for it to finish (with a timeout),
- sequences the serial transmitter through the 4 characters: hundreds/tens/units digits, then "#".
Pure Moore FSM plus one timeout/interval counter. Sits beside the datapath; its outputs drive the datapath's zera/medir/conta/partida.

Parameters:
TIMEOUT_CICLOS, 2_500_000, max cycles in AGUARDA_MEDIDA before error (50 ms @ 50 MHz)
INTERVALO_CICLOS, 25_000_000, idle cycles between measurements in continuous mode (only with macro)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
mensurar  input  1  start request, sampled level; acted on only in INICIAL or ERRO
continuo  input  1  continuous-mode enable (ignored without macro)
fim_medida  input  1  measurement done pulse from sensor interface
fim_digito  input  1  character-sent pulse from serial TX
fim_envio  input  1  character-counter carry (high when counter=3 and conta=1)
zera  output  1  datapath clear
medir  output  1  measurement start pulse
conta  output  1  character counter increment
partida  output  1  serial TX start pulse
pronto  output  1  sequence complete, 1-cycle pulse
erro  output  1  measurement timeout flag
db_estado  output  4  current state code

Behaviour:
- Clock is clock, reset is reset. Reset is synchronous and active-high. Reset → INICIAL, timeout counter 0; all outputs 0, db_estado=0 after the edge. Reset mid-sequence aborts immediately.
- Outputs decode from state only (Moore); no input-to-output combinational path.
- States (db_estado code), transitions, and outputs:
  - INICIAL (0): outputs all 0. mensurar=1 → PREPARACAO.
  - PREPARACAO (1): zera=1 for 1 cycle → MEDIDA.
  - MEDIDA (2): medir=1 for 1 cycle; counter cleared → AGUARDA_MEDIDA.
  - AGUARDA_MEDIDA (3): counter increments each cycle.
    - fim_medida=1 → TRANSMISSAO.
    - else counter = TIMEOUT_CICLOS-1 → ERRO.
    - fim_medida wins if both happen in the same cycle.
  - TRANSMISSAO (4): partida=1 for 1 cycle → ESPERA_DIGITO.
  - ESPERA_DIGITO (5): waits indefinitely for fim_digito=1 → PROXIMO.
  - PROXIMO (6): conta=1 for 1 cycle.
    - fim_envio=1 this cycle → FINAL; counter wraps 3→0.
    - else → TRANSMISSAO.
  - FINAL (7): pronto=1 for 1 cycle → INICIAL, or → INTERVALO (see Optional Feature).
  - INTERVALO (8): counter increments. At INTERVALO_CICLOS-1 → PREPARACAO, or exits early to INICIAL if continuo=0.
  - ERRO (14): erro=1 held. mensurar=1 → PREPARACAO, which clears erro.
  - Unused codes → INICIAL on next edge.
- Sequencing and timing:
  - Exactly 4 partida pulses per successful sequence, 4 conta pulses, 1 medir, 1 zera.
  - Latency mensurar→medir: 2 cycles. fim_digito→next partida: 2 cycles.
- Ignored inputs:
  - mensurar in any state other than INICIAL/ERRO is ignored (no queueing).
  - fim_medida outside AGUARDA_MEDIDA is ignored.
  - fim_digito outside ESPERA_DIGITO is ignored.
- Counter width: $clog2 of max(TIMEOUT_CICLOS, INTERVALO_CICLOS). It never wraps; it is cleared on entry to AGUARDA_MEDIDA and INTERVALO.

Optional Feature:
Macro TRENA_UC_CONTINUO_EN.
- Defined: FINAL → INTERVALO when continuo=1, else → INICIAL. Measurements repeat every sequence + INTERVALO_CICLOS while continuo stays high.
- Undefined: continuo is unused, INTERVALO state and INTERVALO_CICLOS logic are not synthesized, and FINAL always → INICIAL.

Test Plan:
1. TIMEOUT=100. Reset 2 cycles → all outputs 0, db_estado=0. Pulse mensurar → zera at cycle+1, medir at cycle+2; db_estado 1,2,3.
2. fim_medida 10 cycles after medir, then fim_digito 20 cycles after each partida, fim_envio driven on the 4th conta → exactly 4 partida and 4 conta pulses; pronto 1 cycle; ends with db_estado=0.
3. No fim_medida → erro=1 and db_estado=14 exactly 100 cycles after entering AGUARDA_MEDIDA. Then mensurar → erro=0, new medir pulse.
4. mensurar and spurious fim_digito asserted during AGUARDA_MEDIDA → no state change and no extra pulses.
5. reset asserted while in ESPERA_DIGITO → next edge db_estado=0, all outputs 0; later mensurar restarts a clean sequence.
6. With TRENA_UC_CONTINUO_EN, INTERVALO=50, continuo=1 → a second medir pulse 52 cycles after pronto. Drop continuo during INTERVALO → return to state 0 with no medir.
